// File: rtl/ram_pkg.sv
// Shared definitions for the byte-enabled dual-port RAM: write-mode codes,
// sequencer state encoding and the lane-count helper.
package ram_pkg;

    localparam int RAM_READ_FIRST  = 0;
    localparam int RAM_WRITE_FIRST = 1;

    typedef enum logic {
        RAM_CLEAR = 1'b0,
        RAM_RUN   = 1'b1
    } ram_state_e;

    // Number of byte-enable lanes in one data word.
    function automatic int ram_nb(input int width, input int byte_w);
        return width / byte_w;
    endfunction

endpackage

// File: rtl/ram_rd_pipe.sv
// Extra read-latency stages placed after the array read register.
// STAGES = 0 degenerates to a wire so RD_LATENCY = 1 costs nothing.
module ram_rd_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    generate
        if (STAGES == 0) begin : g_bypass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign data_o         = data_i;
            assign valid_o        = valid_i;
        end else begin : g_pipe
            logic [WIDTH-1:0]  data_q [STAGES];
            logic [STAGES-1:0] valid_q;

            // Valid bits shift every cycle; they are the only state reset clears.
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= '0;
                end else begin
                    valid_q[0] <= valid_i;
                    for (int s = 1; s < STAGES; s++) begin
                        valid_q[s] <= valid_q[s-1];
                    end
                end
            end

            // Data advances only with its valid, so each stage holds the last word.
            always_ff @(posedge clk) begin
                if (valid_i) begin
                    data_q[0] <= data_i;
                end
                for (int s = 1; s < STAGES; s++) begin
                    if (valid_q[s-1]) begin
                        data_q[s] <= data_q[s-1];
                    end
                end
            end

            assign data_o  = data_q[STAGES-1];
            assign valid_o = valid_q[STAGES-1];
        end
    endgenerate

endmodule

// File: rtl/ram_dp_be.sv
// Single-clock true dual-port RAM with byte enables, post-reset clear sweep,
// selectable same-port read-during-write and cross-port collision pulse.
module ram_dp_be
    import ram_pkg::*;
#(
    parameter int               WIDTH          = 32,
    parameter int               BYTE_W         = 8,
    parameter int               DEPTH          = 64,
    parameter int               LG_DEPTH       = 6,
    parameter int               RD_LATENCY     = 1,
    parameter int               WRITE_MODE     = RAM_READ_FIRST,
    parameter int               CLEAR_ON_RESET = 1,
    parameter logic [WIDTH-1:0] INIT_VAL       = '0
) (
    input  logic                               clk,
    input  logic                               rst,
    output logic                               ready,
    input  logic                               ena,
    input  logic                               enb,
    input  logic                               wea,
    input  logic                               web,
    input  logic [ram_nb(WIDTH, BYTE_W)-1:0]   bea,
    input  logic [ram_nb(WIDTH, BYTE_W)-1:0]   beb,
    input  logic [LG_DEPTH-1:0]                addra,
    input  logic [LG_DEPTH-1:0]                addrb,
    input  logic [WIDTH-1:0]                   dina,
    input  logic [WIDTH-1:0]                   dinb,
    output logic [WIDTH-1:0]                   douta,
    output logic [WIDTH-1:0]                   doutb,
    output logic                               douta_valid,
    output logic                               doutb_valid,
    output logic                               collision
);

    localparam int                NB        = ram_nb(WIDTH, BYTE_W);
    localparam logic [LG_DEPTH:0] DEPTH_W   = (LG_DEPTH + 1)'(DEPTH);
    localparam logic [LG_DEPTH-1:0] LAST_ADDR = LG_DEPTH'(DEPTH - 1);
    localparam bit                WR_FIRST  = (WRITE_MODE == RAM_WRITE_FIRST);

    ram_state_e          state_q, state_d;
    logic [LG_DEPTH-1:0] clr_cnt_q, clr_cnt_d;

    logic                acc_a, acc_b, in_a, in_b, clearing;
    logic                wr_en_a, wr_en_b;
    logic [LG_DEPTH-1:0] wr_addr_a;
    logic [WIDTH-1:0]    wr_data_a;
    logic [NB-1:0]       wr_be_a;

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [WIDTH-1:0]    rd_a_q, rd_b_q;
    logic                rv_a_q, rv_b_q, coll_q;

    assign clearing = (state_q == RAM_CLEAR);
    assign ready    = (state_q == RAM_RUN);
    assign acc_a    = ena & ready;
    assign acc_b    = enb & ready;
    assign in_a     = ({1'b0, addra} < DEPTH_W);
    assign in_b     = ({1'b0, addrb} < DEPTH_W);

    // The clear sweep borrows port A's write path while no requests are accepted.
    assign wr_en_a   = clearing | (acc_a & wea & in_a);
    assign wr_addr_a = clearing ? clr_cnt_q : addra;
    assign wr_data_a = clearing ? INIT_VAL  : dina;
    assign wr_be_a   = clearing ? '1        : bea;
    assign wr_en_b   = acc_b & web & in_b;

    // Sequencer state register; reset restarts the sweep from address 0.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_RUN;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Sequencer next state: step the clear counter and leave CLEAR after the last word.
    // NOTE: defaults first so no path through this block can infer a latch.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            RAM_CLEAR: begin
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = RAM_RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Array plus both ports' read registers and lane writes, kept together for RAM inference.
    // NOTE: the array itself is never reset; only the read registers and pulses are.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_a_q <= '0;
            rd_b_q <= '0;
            rv_a_q <= 1'b0;
            rv_b_q <= 1'b0;
            coll_q <= 1'b0;
        end else begin
            rv_a_q <= acc_a;
            rv_b_q <= acc_b;
            coll_q <= acc_a & acc_b & (addra == addrb) & (wea | web);

            if (acc_a) begin
                for (int i = 0; i < NB; i++) begin
                    if (!in_a)
                        rd_a_q[i*BYTE_W +: BYTE_W] <= INIT_VAL[i*BYTE_W +: BYTE_W];
                    else if (WR_FIRST && wea && bea[i])
                        rd_a_q[i*BYTE_W +: BYTE_W] <= dina[i*BYTE_W +: BYTE_W];
                    else
                        rd_a_q[i*BYTE_W +: BYTE_W] <= mem_q[addra][i*BYTE_W +: BYTE_W];
                end
            end

            if (acc_b) begin
                for (int i = 0; i < NB; i++) begin
                    if (!in_b)
                        rd_b_q[i*BYTE_W +: BYTE_W] <= INIT_VAL[i*BYTE_W +: BYTE_W];
                    else if (WR_FIRST && web && beb[i])
                        rd_b_q[i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
                    else
                        rd_b_q[i*BYTE_W +: BYTE_W] <= mem_q[addrb][i*BYTE_W +: BYTE_W];
                end
            end

            // Port B's lane writes come last so it wins on overlapping lanes.
            for (int i = 0; i < NB; i++) begin
                if (wr_en_a && wr_be_a[i])
                    mem_q[wr_addr_a][i*BYTE_W +: BYTE_W] <= wr_data_a[i*BYTE_W +: BYTE_W];
            end
            for (int i = 0; i < NB; i++) begin
                if (wr_en_b && beb[i])
                    mem_q[addrb][i*BYTE_W +: BYTE_W] <= dinb[i*BYTE_W +: BYTE_W];
            end
        end
    end

    assign collision = coll_q;

    ram_rd_pipe #(.WIDTH(WIDTH), .STAGES(RD_LATENCY - 1)) u_pipe_a (
        .clk     (clk),
        .rst     (rst),
        .data_i  (rd_a_q),
        .valid_i (rv_a_q),
        .data_o  (douta),
        .valid_o (douta_valid)
    );

    ram_rd_pipe #(.WIDTH(WIDTH), .STAGES(RD_LATENCY - 1)) u_pipe_b (
        .clk     (clk),
        .rst     (rst),
        .data_i  (rd_b_q),
        .valid_i (rv_b_q),
        .data_o  (doutb),
        .valid_o (doutb_valid)
    );

endmodule

// File: tb/tb_ram_dp_be.sv
// Bench for ram_dp_be: two instances share stimulus, one READ_FIRST with
// RD_LATENCY=1 and one WRITE_FIRST with RD_LATENCY=3, both clearing to A5A5A5A5.
module tb_ram_dp_be;

    localparam logic [31:0] IV = 32'hA5A5A5A5;

    typedef struct {
        logic        ena, wea;
        logic [3:0]  bea;
        logic [5:0]  addra;
        logic [31:0] dina;
        logic        enb, web;
        logic [3:0]  beb;
        logic [5:0]  addrb;
        logic [31:0] dinb;
        logic [31:0] a_rf, a_wf, b_rf, b_wf;
        logic        coll;
    } vec_t;

    typedef struct {
        int          due;
        logic [31:0] data;
    } exp_t;

    logic        clk, rst;
    logic        ena, enb, wea, web;
    logic [3:0]  bea, beb;
    logic [5:0]  addra, addrb;
    logic [31:0] dina, dinb;
    logic        ready0, ready1, va0, vb0, va1, vb1, coll0, coll1;
    logic [31:0] douta0, doutb0, douta1, doutb1;

    int   cyc    = 0;
    int   n_vec  = 0;
    int   n_miss = 0;
    bit   tb_ready = 0;
    exp_t q [4][$];      // 0: u0 A, 1: u1 A, 2: u0 B, 3: u1 B
    bit   coll_exp [int];
    vec_t vecs [$];
    vec_t idle;

    ram_dp_be #(.RD_LATENCY(1), .WRITE_MODE(0), .CLEAR_ON_RESET(1), .INIT_VAL(IV)) u0 (
        .clk(clk), .rst(rst), .ready(ready0),
        .ena(ena), .enb(enb), .wea(wea), .web(web), .bea(bea), .beb(beb),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .douta(douta0), .doutb(doutb0), .douta_valid(va0), .doutb_valid(vb0),
        .collision(coll0)
    );

    ram_dp_be #(.RD_LATENCY(3), .WRITE_MODE(1), .CLEAR_ON_RESET(1), .INIT_VAL(IV)) u1 (
        .clk(clk), .rst(rst), .ready(ready1),
        .ena(ena), .enb(enb), .wea(wea), .web(web), .bea(bea), .beb(beb),
        .addra(addra), .addrb(addrb), .dina(dina), .dinb(dinb),
        .douta(douta1), .doutb(doutb1), .douta_valid(va1), .doutb_valid(vb1),
        .collision(coll1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic vec_t mkv(
        input logic ena_v, input logic wea_v, input logic [3:0] bea_v,
        input logic [5:0] addra_v, input logic [31:0] dina_v,
        input logic enb_v, input logic web_v, input logic [3:0] beb_v,
        input logic [5:0] addrb_v, input logic [31:0] dinb_v,
        input logic [31:0] a_rf, input logic [31:0] a_wf,
        input logic [31:0] b_rf, input logic [31:0] b_wf, input logic coll);
        vec_t v;
        v.ena = ena_v; v.wea = wea_v; v.bea = bea_v; v.addra = addra_v; v.dina = dina_v;
        v.enb = enb_v; v.web = web_v; v.beb = beb_v; v.addrb = addrb_v; v.dinb = dinb_v;
        v.a_rf = a_rf; v.a_wf = a_wf; v.b_rf = b_rf; v.b_wf = b_wf; v.coll = coll;
        return v;
    endfunction

    // Memory contents after the vector table has run.
    function automatic logic [31:0] exp_mem(input int a);
        case (a)
            3:       return 32'hCAFEF00D;
            4:       return 32'h0BADBEEF;
            5:       return 32'h11FF33FF;
            7:       return 32'hDEADBEEF;
            9:       return 32'h11222222;
            default: return IV;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon_port(input int idx, input string name, input logic v, input logic [31:0] d);
        exp_t e;
        if (v === 1'b1) begin
            if (q[idx].size() == 0) begin
                check({name, " unexpected valid"}, 32'd1, 32'd0);
            end else begin
                e = q[idx].pop_front();
                check({name, " latency"}, cyc, e.due);
                check({name, " data"}, d, e.data);
            end
        end else if (v !== 1'b0) begin
            check({name, " valid unknown"}, {31'd0, v}, 32'd0);
        end
    endtask

    task automatic monitor();
        check("ready u0", {31'd0, ready0}, {31'd0, tb_ready});
        check("ready u1", {31'd0, ready1}, {31'd0, tb_ready});
        mon_port(0, "u0 porta", va0, douta0);
        mon_port(1, "u1 porta", va1, douta1);
        mon_port(2, "u0 portb", vb0, doutb0);
        mon_port(3, "u1 portb", vb1, doutb1);
        if (coll_exp.exists(cyc)) begin
            check("u0 collision", {31'd0, coll0}, {31'd0, coll_exp[cyc]});
            check("u1 collision", {31'd0, coll1}, {31'd0, coll_exp[cyc]});
            coll_exp.delete(cyc);
        end else if (coll0 !== 1'b0 || coll1 !== 1'b0) begin
            check("collision unexpected", {30'd0, coll1, coll0}, 32'd0);
        end
    endtask

    task automatic drive(input vec_t v);
        ena = v.ena; wea = v.wea; bea = v.bea; addra = v.addra; dina = v.dina;
        enb = v.enb; web = v.web; beb = v.beb; addrb = v.addrb; dinb = v.dinb;
        if (tb_ready && !rst) begin
            if (v.ena) begin
                q[0].push_back(exp_t'{cyc + 1, v.a_rf});
                q[1].push_back(exp_t'{cyc + 3, v.a_wf});
            end
            if (v.enb) begin
                q[2].push_back(exp_t'{cyc + 1, v.b_rf});
                q[3].push_back(exp_t'{cyc + 3, v.b_wf});
            end
            coll_exp[cyc + 1] = v.coll;
        end
    endtask

    task automatic step(input vec_t v);
        @(negedge clk);
        monitor();
        drive(v);
    endtask

    // Reads still in flight when reset is sampled must never emerge.
    task automatic flush();
        for (int i = 0; i < 4; i++) begin
            while (q[i].size() > 0 && q[i][$].due > cyc) void'(q[i].pop_back());
        end
    endtask

    task automatic step_rst();
        @(negedge clk);
        monitor();
        rst = 1'b1;
        tb_ready = 1'b0;
        flush();
        drive(idle);
    endtask

    task automatic chk_reset(input string tag);
        check({tag, " ready u0"}, {31'd0, ready0}, 32'd0);
        check({tag, " ready u1"}, {31'd0, ready1}, 32'd0);
        check({tag, " douta u0"}, douta0, 32'd0);
        check({tag, " doutb u0"}, doutb0, 32'd0);
        check({tag, " valids"}, {28'd0, va0, vb0, va1, vb1}, 32'd0);
        check({tag, " collision"}, {30'd0, coll0, coll1}, 32'd0);
    endtask

    // Release reset and follow the sweep; abort_at > 0 reasserts reset after that many cycles.
    task automatic sweep(input int abort_at);
        vec_t dropped;
        dropped = mkv(1, 1, 4'hF, 6'd3, 32'h0, 1, 1, 4'hF, 6'd4, 32'h0, 0, 0, 0, 0, 0);
        @(negedge clk);
        monitor();
        rst = 1'b0;
        drive(idle);
        for (int k = 1; k <= 64; k++) begin
            tb_ready = (k == 64);
            @(negedge clk);
            monitor();
            if (k == abort_at) begin
                rst = 1'b1;
                tb_ready = 1'b0;
                flush();
                drive(idle);
                return;
            end
            drive((k == 10) ? dropped : idle);
        end
    endtask

    initial begin
        idle = mkv(0, 0, 4'h0, 6'd0, 32'h0, 0, 0, 4'h0, 6'd0, 32'h0, 0, 0, 0, 0, 0);

        //              ena wea bea    addra  dina          enb web beb    addrb  dinb
        //              a_rf          a_wf          b_rf          b_wf          coll
        vecs.push_back(mkv(1, 0, 4'h0, 6'd0,  32'h0,        1, 0, 4'h0, 6'd63, 32'h0,
                           IV,           IV,           IV,           IV,           0));
        vecs.push_back(mkv(1, 1, 4'hF, 6'd5,  32'h11223344, 0, 0, 4'h0, 6'd0,  32'h0,
                           IV,           32'h11223344, 32'h0,        32'h0,        0));
        vecs.push_back(mkv(1, 1, 4'h5, 6'd5,  32'hFFFFFFFF, 0, 0, 4'h0, 6'd0,  32'h0,
                           32'h11223344, 32'h11FF33FF, 32'h0,        32'h0,        0));
        vecs.push_back(mkv(1, 0, 4'h0, 6'd5,  32'h0,        0, 0, 4'h0, 6'd0,  32'h0,
                           32'h11FF33FF, 32'h11FF33FF, 32'h0,        32'h0,        0));
        vecs.push_back(mkv(1, 1, 4'hF, 6'd7,  32'h0,        0, 0, 4'h0, 6'd0,  32'h0,
                           IV,           32'h0,        32'h0,        32'h0,        0));
        vecs.push_back(mkv(1, 1, 4'hF, 6'd7,  32'hDEADBEEF, 1, 0, 4'h0, 6'd7,  32'h0,
                           32'h0,        32'hDEADBEEF, 32'h0,        32'h0,        1));
        vecs.push_back(mkv(1, 1, 4'hF, 6'd9,  32'h00000022, 0, 0, 4'h0, 6'd0,  32'h0,
                           IV,           32'h00000022, 32'h0,        32'h0,        0));
        vecs.push_back(mkv(1, 1, 4'hC, 6'd9,  32'h11111111, 1, 1, 4'h6, 6'd9,  32'h22222222,
                           32'h00000022, 32'h11110022, 32'h00000022, 32'h00222222, 1));
        vecs.push_back(mkv(1, 0, 4'h0, 6'd9,  32'h0,        1, 0, 4'h0, 6'd7,  32'h0,
                           32'h11222222, 32'h11222222, 32'hDEADBEEF, 32'hDEADBEEF, 0));
        vecs.push_back(mkv(1, 0, 4'h0, 6'd5,  32'h0,        1, 0, 4'h0, 6'd5,  32'h0,
                           32'h11FF33FF, 32'h11FF33FF, 32'h11FF33FF, 32'h11FF33FF, 0));
        vecs.push_back(mkv(1, 1, 4'h0, 6'd5,  32'h0,        0, 0, 4'h0, 6'd0,  32'h0,
                           32'h11FF33FF, 32'h11FF33FF, 32'h0,        32'h0,        0));
        vecs.push_back(mkv(1, 0, 4'h0, 6'd9,  32'h0,        1, 1, 4'h0, 6'd9,  32'hFFFFFFFF,
                           32'h11222222, 32'h11222222, 32'h11222222, 32'h11222222, 1));
        vecs.push_back(mkv(1, 1, 4'hF, 6'd3,  32'hCAFEF00D, 1, 1, 4'hF, 6'd4,  32'h0BADBEEF,
                           IV,           32'hCAFEF00D, IV,           32'h0BADBEEF, 0));
        vecs.push_back(mkv(1, 0, 4'h0, 6'd4,  32'h0,        1, 0, 4'h0, 6'd3,  32'h0,
                           32'h0BADBEEF, 32'h0BADBEEF, 32'hCAFEF00D, 32'hCAFEF00D, 0));

        // Power-on reset and first clear sweep.
        rst = 1'b1;
        drive(idle);
        repeat (3) step(idle);
        chk_reset("por");
        sweep(0);

        // Directed vector table.
        foreach (vecs[i]) step(vecs[i]);
        repeat (4) step(idle);

        // Back-to-back reads on both ports, addresses 0..15.
        for (int i = 0; i < 16; i++) begin
            step(mkv(1, 0, 4'h0, 6'(i), 32'h0, 1, 0, 4'h0, 6'(15 - i), 32'h0,
                     exp_mem(i), exp_mem(i), exp_mem(15 - i), exp_mem(15 - i), 0));
        end
        repeat (4) step(idle);

        // Reset in the middle of a sweep, then a full sweep must restore every word.
        step(mkv(1, 1, 4'hF, 6'd40, 32'h12345678, 0, 0, 4'h0, 6'd0, 32'h0,
                 IV, 32'h12345678, 32'h0, 32'h0, 0));
        repeat (3) step(idle);
        step_rst();
        step(idle);
        chk_reset("pre-sweep");
        sweep(30);
        step(idle);
        chk_reset("mid-sweep");
        sweep(0);
        step(mkv(1, 0, 4'h0, 6'd5, 32'h0, 1, 0, 4'h0, 6'd40, 32'h0, IV, IV, IV, IV, 0));
        repeat (4) step(idle);

        // Reset with reads in flight on both ports.
        step(mkv(1, 0, 4'h0, 6'd0, 32'h0, 1, 0, 4'h0, 6'd1, 32'h0, IV, IV, IV, IV, 0));
        step(mkv(1, 0, 4'h0, 6'd2, 32'h0, 1, 0, 4'h0, 6'd3, 32'h0, IV, IV, IV, IV, 0));
        step_rst();
        step(idle);
        chk_reset("in-flight");
        repeat (4) step(idle);
        sweep(0);
        step(mkv(1, 0, 4'h0, 6'd63, 32'h0, 1, 0, 4'h0, 6'd0, 32'h0, IV, IV, IV, IV, 0));
        repeat (4) step(idle);

        check("scoreboard drained", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/ram_dp_be.md
# ram_dp_be

Single-clock true dual-port RAM with per-byte write enables, a configurable read pipeline and a selectable read-during-write mode. It adds a post-reset clear sequencer and cross-port collision reporting. It is the general-purpose on-chip buffer for blocks that need two independent random-access ports in one clock domain. The storage array remains behaviourally inferable as block RAM; the clear sequencer, pipelines and collision logic sit around it.

## Interface
Parameters:
- WIDTH, 32, data width in bits; must be a multiple of BYTE_W
- BYTE_W, 8, bits per byte-enable lane; NB = WIDTH/BYTE_W lanes
- DEPTH, 64, number of words; DEPTH ≤ 2^LG_DEPTH
- LG_DEPTH, 6, address width
- RD_LATENCY, 1, cycles from accepted request to dout_valid; legal range 1..3
- WRITE_MODE, 0, same-port read-during-write: 0 = READ_FIRST, 1 = WRITE_FIRST
- CLEAR_ON_RESET, 1, 1 = sweep every word to INIT_VAL after reset
- INIT_VAL, 0, WIDTH-bit clear/initial value

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ready  out  1  high when requests are accepted
- ena, enb  in  1  port request strobe
- wea, web  in  1  write qualifier (request is a write when high)
- bea, beb  in  NB  byte-lane write enables; bit i covers din[i*BYTE_W +: BYTE_W]
- addra, addrb  in  LG_DEPTH  word address
- dina, dinb  in  WIDTH  write data
- douta, doutb  out  WIDTH  read data
- douta_valid, doutb_valid  out  1  one-cycle pulse marking new read data
- collision  out  1  one-cycle pulse for a same-address cross-port conflict

## Operation
- Accepted request: en && ready. Requests while ready=0 are dropped silently and produce no valid and no write.
- Each accepted request performs a read; if we=1 it also writes the lanes where be=1. A write with be=0 acts as a pure read.
- Same-port read-during-write:
  - READ_FIRST returns the pre-write word.
  - WRITE_FIRST returns the pre-write word with the enabled lanes replaced by din.
- Cross-port reads always return the pre-cycle contents, regardless of WRITE_MODE.
- Both ports write the same address: for overlapping lanes port B wins; non-overlapping lanes from both ports are written.
- collision: asserted the cycle after both requests are accepted with addra==addrb and (wea|web).
- Addresses ≥ DEPTH: the write is ignored; the read returns INIT_VAL; a valid pulse is still produced.
- FSM states:
  - CLEAR: entered on rst when CLEAR_ON_RESET=1. A counter writes INIT_VAL to address 0..DEPTH-1, one word per cycle, through port A's write path. Moves to RUN after address DEPTH-1 is written.
  - RUN: ready=1.
  - With CLEAR_ON_RESET=0, rst goes directly to RUN and memory contents are preserved.
- Reset values: ready=0 (CLEAR_ON_RESET=1) or 1 (otherwise); douta/doutb=0; valids=0; collision=0; clear counter=0.
- Reset mid-clear restarts the sweep at address 0.
- Reset with reads in flight discards them; no valid pulse emerges.

## Timing
- Request in cycle t produces dout/dout_valid in cycle t+RD_LATENCY.
- Throughput is one request per port per cycle, back-to-back, with no bubbles.
- dout holds its last value when dout_valid=0.
- Clear sweep: rst deasserted at cycle r gives ready=1 at cycle r+DEPTH. A request at r+DEPTH is accepted.
- collision is asserted at t+1 independent of RD_LATENCY.
- rst has priority over every other input in its cycle.

## Structure
- Shared package ram_pkg:
  - WRITE_MODE encodings RAM_READ_FIRST=0, RAM_WRITE_FIRST=1.
  - FSM state encoding RAM_CLEAR, RAM_RUN.
  - A function computing NB from WIDTH and BYTE_W.
- Sub-module ram_rd_pipe, instantiated once per port:
  - RD_LATENCY-1 stage data+valid delay line after the array read register.
  - Synchronous reset clears the valids only.
- The array and both port write/read paths stay in one always block so the single-clock dual-port RAM is inferred.

## Test plan
- Clear sweep: DEPTH=64, INIT_VAL=32'hA5A5A5A5, release rst → ready rises exactly 64 cycles later; reading addr 0 and addr 63 returns 32'hA5A5A5A5.
- Byte enables: write 32'h11223344 to addr 5 with be=4'b1111, then 32'hFFFFFFFF with be=4'b0101 → read of addr 5 returns 32'h11FF33FF at t+RD_LATENCY.
- Read-during-write: addr 7 holds 32'h0; port A writes 32'hDEADBEEF to addr 7 → dout is 32'h0 under READ_FIRST and 32'hDEADBEEF under WRITE_FIRST; a same-cycle port B read of addr 7 returns 32'h0 in both modes.
- Collision: both ports write addr 9 in the same cycle (A=32'h1111_1111 with be=4'b1100, B=32'h2222_2222 with be=4'b0110) → collision pulses at t+1; a later read returns 32'h1122_2222.
- Pipeline: RD_LATENCY=3, back-to-back reads of addr 0..15 on both ports → 16 consecutive valid pulses per port starting at t+3; no gaps.
- Reset mid-operation: assert rst during the sweep at address 30 and again with two reads in flight → sweep restarts at 0; no valid pulse emerges from the discarded reads; outputs return to their reset values.
